// File: rtl/fft_pkg.sv
// Shared types and defaults for the radix-2 DIT FFT stage sequencer.
package fft_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam int LOG2N_DEF  = 8;
   localparam int BF_LAT_DEF = 6;
   localparam int RD_LAT_DEF = 1;

   // Cycles from a read strobe to the matching write-back.
   function automatic int pipe_len(input int rd_lat, input int bf_lat);
      return rd_lat + bf_lat;
   endfunction

   localparam int PIPE_DEF = RD_LAT_DEF + BF_LAT_DEF;

endpackage

// File: rtl/fft_wr_delay.sv
// Fixed-depth shift register carrying {valid, addr_a, addr_b} from the read
// side of the butterfly to its write-back side. Reset clears every stage so
// no write strobe can escape after a reset.
module fft_wr_delay #(
   parameter int DEPTH = 3,
   parameter int AW    = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [AW-1:0] in_addr_a,
   input  logic [AW-1:0] in_addr_b,
   output logic          out_valid,
   output logic [AW-1:0] out_addr_a,
   output logic [AW-1:0] out_addr_b
);

   typedef struct packed {
      logic          valid;
      logic [AW-1:0] addr_a;
      logic [AW-1:0] addr_b;
   } slot_t;

   slot_t slot_reg [DEPTH];

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
         if (gi == 0) begin : g_head
            // First slot captures the read-side strobe and addresses.
            always_ff @(posedge clk) begin
               if (rst) begin
                  slot_reg[gi] <= '0;
               end else begin
                  slot_reg[gi] <= '{valid: in_valid, addr_a: in_addr_a, addr_b: in_addr_b};
               end
            end
         end else begin : g_body
            // Remaining slots shift the previous slot forward one cycle.
            always_ff @(posedge clk) begin
               if (rst) begin
                  slot_reg[gi] <= '0;
               end else begin
                  slot_reg[gi] <= slot_reg[gi-1];
               end
            end
         end
      end
   endgenerate

   assign out_valid  = slot_reg[DEPTH-1].valid;
   assign out_addr_a = slot_reg[DEPTH-1].addr_a;
   assign out_addr_b = slot_reg[DEPTH-1].addr_b;

endmodule

// File: rtl/fft_bfly_sched.sv
// In-place radix-2 DIT FFT stage sequencer: walks every butterfly of every
// stage, issues data-RAM reads plus the twiddle address, and replays each
// pair's addresses as a write-back once the read and butterfly latency expire.
module fft_bfly_sched
   import fft_pkg::*;
#(
   parameter int LOG2N  = LOG2N_DEF,
   parameter int BF_LAT = BF_LAT_DEF,
   parameter int RD_LAT = RD_LAT_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [3:0]       stage,
   output logic             rd_en,
   output logic [LOG2N-1:0] rd_addr_a,
   output logic [LOG2N-1:0] rd_addr_b,
   output logic [LOG2N-2:0] tw_addr,
   output logic             wr_en,
   output logic [LOG2N-1:0] wr_addr_a,
   output logic [LOG2N-1:0] wr_addr_b
);

   localparam int PIPE = pipe_len(RD_LAT, BF_LAT);
   localparam int KW   = LOG2N - 1;
   localparam int DW   = (PIPE > 1) ? $clog2(PIPE) : 1;

   localparam logic [KW-1:0] K_LAST     = '1;
   localparam logic [3:0]    S_LAST     = 4'(LOG2N - 1);
   localparam logic [DW-1:0] DRAIN_LOAD = DW'(PIPE - 1);

   state_t           state_reg, state_next;
   logic [KW-1:0]    k_reg, k_next;
   logic [3:0]       stage_reg, stage_next;
   logic [DW-1:0]    drain_reg, drain_next;

   logic             rd_en_reg, busy_reg, done_reg;
   logic [LOG2N-1:0] addr_a_reg, addr_a_next;
   logic [LOG2N-1:0] addr_b_reg, addr_b_next;
   logic [KW-1:0]    tw_reg, tw_next;

   logic [LOG2N-1:0] k_ext, half, pos, grp, tw_wide;

   // Next-state logic plus the butterfly address for the next issued k.
   always_comb begin
      state_next = state_reg;
      k_next     = k_reg;
      stage_next = stage_reg;
      drain_next = drain_reg;

      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               state_next = ST_RUN;
               k_next     = '0;
               stage_next = '0;
            end
         end
         ST_RUN: begin
            if (k_reg == K_LAST) begin
               state_next = ST_DRAIN;
               drain_next = DRAIN_LOAD;
               k_next     = '0;
            end else begin
               k_next = k_reg + KW'(1);
            end
         end
         ST_DRAIN: begin
            if (drain_reg == '0) begin
               if (stage_reg == S_LAST) begin
                  state_next = ST_DONE;
               end else begin
                  state_next = ST_RUN;
                  stage_next = stage_reg + 4'd1;
                  k_next     = '0;
               end
            end else begin
               drain_next = drain_reg - DW'(1);
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
            stage_next = '0;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase

      // pos selects the twiddle and low address bits, grp the butterfly block.
      k_ext       = {1'b0, k_next};
      half        = LOG2N'(1) << stage_next;
      pos         = k_ext & (half - LOG2N'(1));
      grp         = k_ext >> stage_next;
      addr_a_next = (grp << (stage_next + 4'd1)) | pos;
      addr_b_next = addr_a_next | half;
      tw_wide     = pos << (S_LAST - stage_next);
      tw_next     = tw_wide[KW-1:0];
   end

   // FSM state, counters and the registered read-side outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= ST_IDLE;
         k_reg      <= '0;
         stage_reg  <= '0;
         drain_reg  <= '0;
         rd_en_reg  <= 1'b0;
         busy_reg   <= 1'b0;
         done_reg   <= 1'b0;
         addr_a_reg <= '0;
         addr_b_reg <= '0;
         tw_reg     <= '0;
      end else begin
         state_reg <= state_next;
         k_reg     <= k_next;
         stage_reg <= stage_next;
         drain_reg <= drain_next;
         rd_en_reg <= (state_next == ST_RUN);
         busy_reg  <= (state_next != ST_IDLE);
         done_reg  <= (state_next == ST_DONE);
         if (state_next == ST_RUN) begin
            addr_a_reg <= addr_a_next;
            addr_b_reg <= addr_b_next;
            tw_reg     <= tw_next;
         end else begin
            addr_a_reg <= '0;
            addr_b_reg <= '0;
            tw_reg     <= '0;
         end
      end
   end

   fft_wr_delay #(
      .DEPTH (PIPE),
      .AW    (LOG2N)
   ) u_wr_delay (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (rd_en_reg),
      .in_addr_a  (addr_a_reg),
      .in_addr_b  (addr_b_reg),
      .out_valid  (wr_en),
      .out_addr_a (wr_addr_a),
      .out_addr_b (wr_addr_b)
   );

   assign busy      = busy_reg;
   assign done      = done_reg;
   assign stage     = stage_reg;
   assign rd_en     = rd_en_reg;
   assign rd_addr_a = addr_a_reg;
   assign rd_addr_b = addr_b_reg;
   assign tw_addr   = tw_reg;

endmodule

// File: tb/tb_fft_bfly_sched.sv
// Self-checking bench for fft_bfly_sched with LOG2N=3, BF_LAT=2, RD_LAT=1.
module tb_fft_bfly_sched;

   localparam int PIPE   = 3;
   localparam int TX_LEN = 22;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       busy, done, rd_en, wr_en;
   logic [3:0] stage;
   logic [2:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
   logic [1:0] tw_addr;

   fft_bfly_sched #(.LOG2N(3), .BF_LAT(2), .RD_LAT(1)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .stage     (stage),
      .rd_en     (rd_en),
      .rd_addr_a (rd_addr_a),
      .rd_addr_b (rd_addr_b),
      .tw_addr   (tw_addr),
      .wr_en     (wr_en),
      .wr_addr_a (wr_addr_a),
      .wr_addr_b (wr_addr_b)
   );

   always #5 clk = ~clk;

   typedef struct {
      int s;
      int k;
      int a;
      int b;
      int tw;
   } vec_t;

   typedef struct {
      int cyc;
      int s;
      int a;
      int b;
      int tw;
   } rd_exp_t;

   typedef struct {
      int cyc;
      int a;
      int b;
   } wr_exp_t;

   vec_t    tbl [12];
   rd_exp_t rd_q [$];
   wr_exp_t wr_q [$];
   int      done_q [$];

   int cyc = 0;
   int busy_cnt = 0;
   int n_chk = 0;
   int n_pass = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   // Queue the full expected read/write/done trace for a transform accepted at acc.
   task automatic push_expect(input int acc);
      for (int i = 0; i < 12; i++) begin
         rd_q.push_back('{cyc: acc + tbl[i].s * 7 + tbl[i].k, s: tbl[i].s,
                          a: tbl[i].a, b: tbl[i].b, tw: tbl[i].tw});
         wr_q.push_back('{cyc: acc + tbl[i].s * 7 + tbl[i].k + PIPE,
                          a: tbl[i].a, b: tbl[i].b});
      end
      done_q.push_back(acc + TX_LEN - 1);
   endtask

   // Called on a negedge while idle: pulse start and record the acceptance cycle.
   task automatic start_tx(output int acc);
      start = 1'b1;
      acc = cyc + 1;
      push_expect(acc);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic poke_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_until(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic finish_check(input string tag, input int b0, input int exp_busy);
      int t;
      t = 0;
      while ((rd_q.size() != 0 || wr_q.size() != 0 || done_q.size() != 0) && t < 300) begin
         @(negedge clk);
         t++;
      end
      repeat (5) @(negedge clk);
      chk({tag, "_reads_left"}, rd_q.size(), 0);
      chk({tag, "_writes_left"}, wr_q.size(), 0);
      chk({tag, "_done_left"}, done_q.size(), 0);
      chk({tag, "_busy_cycles"}, busy_cnt - b0, exp_busy);
   endtask

   // Monitor: every read, write and done pulse is matched against the scoreboard.
   always @(negedge clk) begin
      rd_exp_t re;
      wr_exp_t we;
      if (busy) busy_cnt++;
      if (rd_en) begin
         $display("rd  cyc=%0d s=%0d a=%0d b=%0d tw=%0d", cyc, stage, rd_addr_a, rd_addr_b, tw_addr);
         if (rd_q.size() == 0) begin
            chk("rd_unexpected", 1, 0);
         end else begin
            re = rd_q.pop_front();
            chk("rd_cycle", cyc, re.cyc);
            chk("rd_stage", int'(stage), re.s);
            chk("rd_addr_a", int'(rd_addr_a), re.a);
            chk("rd_addr_b", int'(rd_addr_b), re.b);
            chk("tw_addr", int'(tw_addr), re.tw);
         end
      end
      if (wr_en) begin
         $display("wr  cyc=%0d a=%0d b=%0d", cyc, wr_addr_a, wr_addr_b);
         if (wr_q.size() == 0) begin
            chk("wr_unexpected", 1, 0);
         end else begin
            we = wr_q.pop_front();
            chk("wr_cycle", cyc, we.cyc);
            chk("wr_addr_a", int'(wr_addr_a), we.a);
            chk("wr_addr_b", int'(wr_addr_b), we.b);
         end
      end
      if (done) begin
         $display("done cyc=%0d", cyc);
         if (done_q.size() == 0) chk("done_unexpected", 1, 0);
         else chk("done_cycle", cyc, done_q.pop_front());
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc, acc2, b0;

      tbl[0]  = '{0, 0, 0, 1, 0};
      tbl[1]  = '{0, 1, 2, 3, 0};
      tbl[2]  = '{0, 2, 4, 5, 0};
      tbl[3]  = '{0, 3, 6, 7, 0};
      tbl[4]  = '{1, 0, 0, 2, 0};
      tbl[5]  = '{1, 1, 1, 3, 2};
      tbl[6]  = '{1, 2, 4, 6, 0};
      tbl[7]  = '{1, 3, 5, 7, 2};
      tbl[8]  = '{2, 0, 0, 4, 0};
      tbl[9]  = '{2, 1, 1, 5, 1};
      tbl[10] = '{2, 2, 2, 6, 2};
      tbl[11] = '{2, 3, 3, 7, 3};

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_stage", int'(stage), 0);
      chk("rst_rd_en", int'(rd_en), 0);
      chk("rst_rd_addr_a", int'(rd_addr_a), 0);
      chk("rst_rd_addr_b", int'(rd_addr_b), 0);
      chk("rst_tw_addr", int'(tw_addr), 0);
      chk("rst_wr_en", int'(wr_en), 0);
      chk("rst_wr_addrs", int'({wr_addr_a, wr_addr_b}), 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Basic transform: address trace, write alignment, timing
      b0 = busy_cnt;
      start_tx(acc);
      finish_check("basic", b0, TX_LEN);

      // start re-pulsed mid-RUN and during DONE is ignored
      b0 = busy_cnt;
      start_tx(acc);
      wait_until(acc + 1);
      poke_start();
      wait_until(acc + TX_LEN - 1);
      poke_start();
      finish_check("ignore_start", b0, TX_LEN);

      // Reset during stage-1 drain drops in-flight writes
      start_tx(acc);
      wait_until(acc + 11);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_rd_en", int'(rd_en), 0);
      chk("midrst_wr_en", int'(wr_en), 0);
      chk("midrst_done", int'(done), 0);
      chk("midrst_reads_pending", rd_q.size(), 4);
      chk("midrst_writes_pending", wr_q.size(), 6);
      rd_q.delete();
      wr_q.delete();
      done_q.delete();
      b0 = busy_cnt;
      repeat (12) @(negedge clk);
      chk("midrst_quiet_busy", busy_cnt - b0, 0);
      b0 = busy_cnt;
      start_tx(acc);
      finish_check("after_rst", b0, TX_LEN);

      // Back-to-back transforms: start in the cycle after done
      b0 = busy_cnt;
      start_tx(acc);
      wait_until(acc + TX_LEN);
      start_tx(acc2);
      chk("b2b_accept_gap", acc2 - acc, TX_LEN + 1);
      finish_check("back_to_back", b0, 2 * TX_LEN);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
